cvxif_copro_responder: RTL

- Coprocessor-side (responder) end of the CV-X-IF link that the embedded core drives as initiator; CvxifEn=1, XLEN=32.
- Decodes a small custom-0 instruction set, accepts or rejects each offered instruction, and tracks in-flight ops in an in-order queue.
- Resolves commit/kill per instruction id, then returns results over a valid/ready result channel with backpressure.

---
 rtl/cvxif_copro_pkg.sv | 40 ++++
 rtl/cvxif_copro_decoder.sv | 38 +++
 rtl/cvxif_copro_responder.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/cvxif_copro_pkg.sv
// Shared types and constants for the CV-X-IF coprocessor responder:
// custom-0 encodings, the decoded op set and the in-flight queue entry.
package cvxif_copro_pkg;

  localparam int unsigned XLEN    = 32;
  localparam int unsigned IdWidth = 4;

  localparam logic [6:0] OPC_CUSTOM0  = 7'b0001011;
  localparam logic [6:0] F7_CUS       = 7'b0000000;
  localparam logic [2:0] F3_ADD       = 3'b000;
  localparam logic [2:0] F3_ADD_MULTI = 3'b001;
  localparam logic [2:0] F3_NOP       = 3'b010;
  localparam logic [2:0] F3_SUB       = 3'b011;

  typedef enum logic [1:0] {CUS_ADD, CUS_ADD_MULTI, CUS_SUB, CUS_NOP} op_e;

  typedef enum logic [1:0] {RET_IDLE, RET_EXEC, RET_RESP} ret_state_e;

  typedef struct packed {
    logic [IdWidth-1:0] id;
    logic [4:0]         rd;
    logic               we;
    op_e                op;
    logic [XLEN-1:0]    data;
    logic               committed;
    logic               killed;
  } entry_t;

  function automatic logic [XLEN-1:0] exec_op(input op_e op, input logic [XLEN-1:0] rs1,
                                              input logic [XLEN-1:0] rs2);
    logic [XLEN-1:0] res;
    case (op)
      CUS_ADD, CUS_ADD_MULTI: res = rs1 + rs2;
      CUS_SUB:                res = rs1 - rs2;
      default:                res = '0;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/cvxif_copro_decoder.sv
// Combinational decode of a custom-0 instruction word into op, operand
// requirements and writeback intent; anything unrecognised is rejected.
module cvxif_copro_decoder
  import cvxif_copro_pkg::*;
(
  input  logic [31:0] instr_i,
  output logic        accept_o,
  output op_e         op_o,
  output logic [1:0]  rs_needed_o,
  output logic        writeback_o,
  output logic [4:0]  rd_o
);

  // Register-source fields are irrelevant: operand values arrive on the bus.
  logic unused_rs_fields;
  assign unused_rs_fields = ^instr_i[24:15];

  always_comb begin
    // NOTE: every signal written here gets a default first, so no latch is inferred.
    accept_o    = 1'b0;
    op_o        = CUS_NOP;
    rs_needed_o = 2'b00;
    if (instr_i[6:0] == OPC_CUSTOM0 && instr_i[31:25] == F7_CUS) begin
      accept_o = 1'b1;
      case (instr_i[14:12])
        F3_ADD:       begin op_o = CUS_ADD;       rs_needed_o = 2'b11; end
        F3_ADD_MULTI: begin op_o = CUS_ADD_MULTI; rs_needed_o = 2'b11; end
        F3_SUB:       begin op_o = CUS_SUB;       rs_needed_o = 2'b11; end
        F3_NOP:       op_o = CUS_NOP;
        default:      accept_o = 1'b0;
      endcase
    end
  end

  assign rd_o        = instr_i[11:7];
  assign writeback_o = accept_o && (op_o != CUS_NOP) && (rd_o != 5'd0);

endmodule

// File: rtl/cvxif_copro_responder.sv
// CV-X-IF responder: accepts custom-0 ops into an in-order queue, resolves
// commit/kill by id and returns results in order over a valid/ready channel.
module cvxif_copro_responder
  import cvxif_copro_pkg::*;
#(
  parameter int unsigned Depth        = 4,
  parameter int unsigned MultiLatency = 3
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 issue_valid_i,
  output logic                 issue_ready_o,
  input  logic [31:0]          issue_instr_i,
  input  logic [IdWidth-1:0]   issue_id_i,
  input  logic [2*XLEN-1:0]    issue_rs_i,
  input  logic [1:0]           issue_rs_valid_i,
  output logic                 issue_accept_o,
  output logic                 issue_writeback_o,
  input  logic                 commit_valid_i,
  input  logic [IdWidth-1:0]   commit_id_i,
  input  logic                 commit_kill_i,
  output logic                 result_valid_o,
  input  logic                 result_ready_i,
  output logic [IdWidth-1:0]   result_id_o,
  output logic [XLEN-1:0]      result_data_o,
  output logic [4:0]           result_rd_o,
  output logic                 result_we_o
);

  localparam int unsigned PtrW = $clog2(Depth);
  localparam int unsigned CntW = $clog2(MultiLatency) + 1;

  logic       dec_accept, dec_writeback;
  op_e        dec_op;
  logic [1:0] dec_rs_needed;
  logic [4:0] dec_rd;

  cvxif_copro_decoder u_decoder (
    .instr_i    (issue_instr_i),
    .accept_o   (dec_accept),
    .op_o       (dec_op),
    .rs_needed_o(dec_rs_needed),
    .writeback_o(dec_writeback),
    .rd_o       (dec_rd)
  );

  entry_t          mem_q [Depth];
  entry_t          mem_d [Depth];
  entry_t          new_entry;
  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [PtrW:0]   count_q, count_d;
  logic [Depth-1:0] live;
  logic            full, issue_fire, enq, pop;

  ret_state_e      state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            head_ready_d;

  assign full              = (count_q == (PtrW+1)'(Depth));
  assign issue_ready_o     = !full && (!dec_accept || (dec_rs_needed & ~issue_rs_valid_i) == 2'b00);
  assign issue_fire        = issue_valid_i && issue_ready_o;
  assign enq               = issue_fire && dec_accept;
  assign issue_accept_o    = enq;
  assign issue_writeback_o = issue_fire && dec_writeback;

  assign new_entry = '{id: issue_id_i, rd: dec_rd, we: dec_writeback, op: dec_op,
                       data: exec_op(dec_op, issue_rs_i[XLEN-1:0], issue_rs_i[2*XLEN-1:XLEN]),
                       committed: 1'b0, killed: 1'b0};

  // Killed heads leave silently; a presented result leaves on its handshake.
  assign pop = (result_valid_o && result_ready_i) ||
               (state_q == RET_IDLE && count_q != '0 && mem_q[rd_ptr_q].killed);

  // A slot takes part in commit matching if it is occupied or being filled now.
  always_comb begin
    for (int i = 0; i < Depth; i++) begin
      live[i] = ({1'b0, PtrW'(i) - rd_ptr_q} < count_q) || (enq && PtrW'(i) == wr_ptr_q);
    end
  end

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q + PtrW'(enq);
    rd_ptr_d = rd_ptr_q + PtrW'(pop);
    count_d  = count_q + (PtrW+1)'(enq) - (PtrW+1)'(pop);
    if (enq) mem_d[wr_ptr_q] = new_entry;
    // Only unresolved entries react, so a presented result never changes under backpressure.
    for (int i = 0; i < Depth; i++) begin
      if (commit_valid_i && live[i] && mem_d[i].id == commit_id_i &&
          !mem_d[i].committed && !mem_d[i].killed) begin
        if (commit_kill_i) mem_d[i].killed    = 1'b1;
        else               mem_d[i].committed = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (!rst_ni) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // NOTE: queue storage is not reset; only slots inside [rd_ptr, rd_ptr+count) are ever read.
  always_ff @(posedge clk_i) begin
    mem_q <= mem_d;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= RET_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // The FSM looks at next cycle's head so execution starts on the commit edge.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    head_ready_d = (count_d != '0) && mem_d[rd_ptr_d].committed && !mem_d[rd_ptr_d].killed;
    case (state_q)
      RET_EXEC: begin
        cnt_d = cnt_q - CntW'(1);
        if (cnt_q == CntW'(1)) state_d = RET_RESP;
      end
      RET_RESP: if (result_ready_i) state_d = RET_IDLE;
      default: ;
    endcase
    if (state_d == RET_IDLE && head_ready_d) begin
      if (mem_d[rd_ptr_d].op == CUS_ADD_MULTI && MultiLatency > 1) begin
        state_d = RET_EXEC;
        cnt_d   = CntW'(MultiLatency - 1);
      end else begin
        state_d = RET_RESP;
      end
    end
  end

  always_comb begin
    result_valid_o = 1'b0;
    result_id_o    = '0;
    result_data_o  = '0;
    result_rd_o    = '0;
    result_we_o    = 1'b0;
    if (state_q == RET_RESP && mem_q[rd_ptr_q].committed) begin
      result_valid_o = 1'b1;
      result_id_o    = mem_q[rd_ptr_q].id;
      result_data_o  = mem_q[rd_ptr_q].data;
      result_rd_o    = mem_q[rd_ptr_q].rd;
      result_we_o    = mem_q[rd_ptr_q].we;
    end
  end

endmodule
